axi_lite_txn_monitor: RTL and testbench

AXI_LITE_TXN_MONITOR -- requirements
Module: axi_lite_txn_monitor

---
 rtl/axi_mon_pkg.sv | 20 ++
 rtl/axi_mon_wait_ctr.sv | 40 ++++
 rtl/axi_lite_txn_monitor.sv | 176 +++++++++++++++++
 tb/tb_axi_lite_txn_monitor.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mon_pkg.sv
// Shared constants for the AXI4-Lite transaction monitor: FSM encodings,
// counter widths and a saturating-increment helper.
package axi_mon_pkg;

  localparam int CNT_W = 32;
  localparam int LAT_W = 16;

  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_WAIT   = 1'b1;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_GOT_AW = 2'd1;
  localparam logic [1:0] W_GOT_W  = 2'd2;
  localparam logic [1:0] W_WAIT_B = 2'd3;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi_mon_wait_ctr.sv
// Per-channel wait counter: measures cycles spent waiting for a response and
// flags the timeout. Latency output present only with AXI_MON_LATENCY_EN.
module axi_mon_wait_ctr
  import axi_mon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             waiting,
  input  logic             done,
  output logic             timeout_hit
`ifdef AXI_MON_LATENCY_EN
  ,
  output logic [LAT_W-1:0] lat
`endif
);

  logic [LAT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= '0;
    end else if (waiting && !done) begin
      cnt_reg <= sat_inc(cnt_reg);
    end
  end

  // Fires on the edge where the count would become TIMEOUT_CYCLES.
  assign timeout_hit = waiting && !done && (cnt_reg == LAT_W'(TIMEOUT_CYCLES - 1));

`ifdef AXI_MON_LATENCY_EN
  // Completing edge counts as one more cycle of latency.
  assign lat = sat_inc(cnt_reg);
`endif

endmodule

// File: rtl/axi_lite_txn_monitor.sv
// Passive AXI4-Lite transaction monitor: counts, last addresses, busy, timeout
// and protocol error flags. Optional AXI_MON_LATENCY_EN adds latency maxima.
module axi_lite_txn_monitor
  import axi_mon_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  clr,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count,
  output logic [ADDR_WIDTH-1:0] last_rd_addr,
  output logic [ADDR_WIDTH-1:0] last_wr_addr,
  output logic                  rd_busy,
  output logic                  wr_busy,
  output logic                  timeout_err,
  output logic                  proto_err
`ifdef AXI_MON_LATENCY_EN
  ,
  output logic [LAT_W-1:0]      rd_lat_max,
  output logic [LAT_W-1:0]      wr_lat_max
`endif
);

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic ar_pend_reg, aw_pend_reg, w_pend_reg;
  logic viol;
  logic [0:0] rd_state_reg, rd_state_next;
  logic [1:0] wr_state_reg, wr_state_next;
  logic rd_start, rd_done, rd_waiting, rd_timeout_hit;
  logic wr_start, wr_done, wr_waiting, wr_timeout_hit;

  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  // A pending valid that disappears without its handshake is a violation.
  assign viol = (ar_pend_reg & ~arvalid) | (aw_pend_reg & ~awvalid) | (w_pend_reg & ~wvalid)
              | (r_hs & (rd_state_reg == R_IDLE))
              | (ar_hs & (rd_state_reg == R_WAIT))
              | (b_hs & (wr_state_reg != W_WAIT_B))
              | ((aw_hs | w_hs) & (wr_state_reg == W_WAIT_B));

  always_comb begin
    rd_state_next = rd_state_reg;
    if (!viol) begin
      case (rd_state_reg)
        R_IDLE:  if (ar_hs) rd_state_next = R_WAIT;
        default: if (r_hs)  rd_state_next = R_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    if (!viol) begin
      case (wr_state_reg)
        W_IDLE: begin
          if (aw_hs && w_hs) wr_state_next = W_WAIT_B;
          else if (aw_hs)    wr_state_next = W_GOT_AW;
          else if (w_hs)     wr_state_next = W_GOT_W;
        end
        W_GOT_AW: if (w_hs)  wr_state_next = W_WAIT_B;
        W_GOT_W:  if (aw_hs) wr_state_next = W_WAIT_B;
        default:  if (b_hs)  wr_state_next = W_IDLE;
      endcase
    end
  end

  assign rd_waiting = (rd_state_reg == R_WAIT);
  assign wr_waiting = (wr_state_reg == W_WAIT_B);
  assign rd_start   = !rd_waiting && (rd_state_next == R_WAIT);
  assign wr_start   = !wr_waiting && (wr_state_next == W_WAIT_B);
  assign rd_done    = rd_waiting && (rd_state_next == R_IDLE);
  assign wr_done    = wr_waiting && (wr_state_next == W_IDLE);
  assign rd_busy    = (rd_state_reg != R_IDLE);
  assign wr_busy    = (wr_state_reg != W_IDLE);

`ifdef AXI_MON_LATENCY_EN
  logic [LAT_W-1:0] rd_lat, wr_lat;
`endif

  axi_mon_wait_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (rd_start),
    .waiting     (rd_waiting),
    .done        (rd_done),
    .timeout_hit (rd_timeout_hit)
`ifdef AXI_MON_LATENCY_EN
    ,
    .lat         (rd_lat)
`endif
  );

  axi_mon_wait_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (wr_start),
    .waiting     (wr_waiting),
    .done        (wr_done),
    .timeout_hit (wr_timeout_hit)
`ifdef AXI_MON_LATENCY_EN
    ,
    .lat         (wr_lat)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg <= R_IDLE;
      wr_state_reg <= W_IDLE;
      ar_pend_reg  <= 1'b0;
      aw_pend_reg  <= 1'b0;
      w_pend_reg   <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
      last_rd_addr <= '0;
      last_wr_addr <= '0;
      timeout_err  <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      wr_state_reg <= wr_state_next;
      ar_pend_reg  <= arvalid & ~arready;
      aw_pend_reg  <= awvalid & ~awready;
      w_pend_reg   <= wvalid & ~wready;
      if (ar_hs) last_rd_addr <= araddr;
      if (aw_hs) last_wr_addr <= awaddr;
      // clr takes priority over a coincident completion or error.
      if (clr) begin
        rd_count    <= '0;
        wr_count    <= '0;
        timeout_err <= 1'b0;
        proto_err   <= 1'b0;
      end else begin
        if (rd_done) rd_count <= rd_count + 1'b1;
        if (wr_done) wr_count <= wr_count + 1'b1;
        if (rd_timeout_hit || wr_timeout_hit) timeout_err <= 1'b1;
        if (viol) proto_err <= 1'b1;
      end
    end
  end

`ifdef AXI_MON_LATENCY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lat_max <= '0;
      wr_lat_max <= '0;
    end else if (clr) begin
      rd_lat_max <= '0;
      wr_lat_max <= '0;
    end else begin
      if (rd_done && (rd_lat > rd_lat_max)) rd_lat_max <= rd_lat;
      if (wr_done && (wr_lat > wr_lat_max)) wr_lat_max <= wr_lat;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_txn_monitor.sv
// Scoreboard bench for axi_lite_txn_monitor (TIMEOUT_CYCLES=8); latency checks
// are active when AXI_MON_LATENCY_EN is defined.
module tb_axi_lite_txn_monitor;

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] addr;
  } exp_t;

  logic        clk, rst_n, clr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr;
  logic [31:0] rd_count, wr_count, last_rd_addr, last_wr_addr;
  logic        rd_busy, wr_busy, timeout_err, proto_err;
`ifdef AXI_MON_LATENCY_EN
  logic [15:0] rd_lat_max, wr_lat_max;
  int          mdl_rd_lat_max, mdl_wr_lat_max;
`endif

  int          checks = 0;
  int          fails  = 0;
  exp_t        rd_q[$];
  exp_t        wr_q[$];
  logic [31:0] mdl_rd, mdl_wr, mdl_last_rd, mdl_last_wr;
  logic [31:0] prev_rd, prev_wr;

  axi_lite_txn_monitor #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .araddr(araddr),
    .clr(clr), .rd_count(rd_count), .wr_count(wr_count),
    .last_rd_addr(last_rd_addr), .last_wr_addr(last_wr_addr),
    .rd_busy(rd_busy), .wr_busy(wr_busy),
    .timeout_err(timeout_err), .proto_err(proto_err)
`ifdef AXI_MON_LATENCY_EN
    , .rd_lat_max(rd_lat_max), .wr_lat_max(wr_lat_max)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every change of a completion counter pops one entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_rd = '0;
      prev_wr = '0;
    end else begin
      if (rd_count !== prev_rd) begin
        if (rd_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL rd_unexpected: got count %0d required no change from %0d", rd_count, prev_rd);
        end else begin
          e = rd_q.pop_front();
          $display("rd txn: count=%0d last_rd_addr=%h", rd_count, last_rd_addr);
          check("rd_count", rd_count, e.cnt);
          check("last_rd_addr", last_rd_addr, e.addr);
        end
        prev_rd = rd_count;
      end
      if (wr_count !== prev_wr) begin
        if (wr_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL wr_unexpected: got count %0d required no change from %0d", wr_count, prev_wr);
        end else begin
          e = wr_q.pop_front();
          $display("wr txn: count=%0d last_wr_addr=%h", wr_count, last_wr_addr);
          check("wr_count", wr_count, e.cnt);
          check("last_wr_addr", last_wr_addr, e.addr);
        end
        prev_wr = wr_count;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic note_rd(input logic [31:0] addr, input int lat);
    mdl_rd      = mdl_rd + 1;
    mdl_last_rd = addr;
    rd_q.push_back({mdl_rd, addr});
`ifdef AXI_MON_LATENCY_EN
    if (lat > mdl_rd_lat_max) mdl_rd_lat_max = lat;
`endif
  endtask

  task automatic note_wr(input logic [31:0] addr, input int lat);
    mdl_wr      = mdl_wr + 1;
    mdl_last_wr = addr;
    wr_q.push_back({mdl_wr, addr});
`ifdef AXI_MON_LATENCY_EN
    if (lat > mdl_wr_lat_max) mdl_wr_lat_max = lat;
`endif
  endtask

  // Counters that are nonzero drop to zero on clr, which the monitor sees as an event.
  task automatic prep_clr();
    if (mdl_rd != 0) rd_q.push_back({32'd0, mdl_last_rd});
    if (mdl_wr != 0) wr_q.push_back({32'd0, mdl_last_wr});
    mdl_rd = '0;
    mdl_wr = '0;
`ifdef AXI_MON_LATENCY_EN
    mdl_rd_lat_max = 0;
    mdl_wr_lat_max = 0;
`endif
  endtask

  task automatic do_clr();
    prep_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_count"}, rd_count, 32'd0);
    check({tag, "_wr_count"}, wr_count, 32'd0);
    check({tag, "_last_rd_addr"}, last_rd_addr, 32'd0);
    check({tag, "_last_wr_addr"}, last_wr_addr, 32'd0);
    check({tag, "_busy"}, {30'd0, rd_busy, wr_busy}, 32'd0);
    check({tag, "_errs"}, {30'd0, timeout_err, proto_err}, 32'd0);
  endtask

  task automatic rd_txn(input logic [31:0] addr, input int k, input int lat);
    araddr  = addr;
    arvalid = 1'b1;
    arready = 1'b0;
    repeat (k) step();
    arready = 1'b1;
    step();
    arvalid = 1'b0;
    arready = 1'b0;
    note_rd(addr, lat);
    check("rd_busy_open", {31'd0, rd_busy}, 32'd1);
    repeat (lat - 1) step();
    check("rd_busy_wait", {31'd0, rd_busy}, 32'd1);
    rvalid = 1'b1;
    rready = 1'b1;
    step();
    rvalid = 1'b0;
    rready = 1'b0;
    check("rd_busy_done", {31'd0, rd_busy}, 32'd0);
  endtask

  // mode 0: AW then W, mode 1: W then AW, mode 2: both together.
  task automatic wr_txn(input logic [31:0] addr, input int mode, input int gap, input int blat);
    note_wr(addr, blat);
    awaddr = addr;
    if (mode == 2) begin
      awvalid = 1'b1; awready = 1'b1; wvalid = 1'b1; wready = 1'b1;
      step();
    end else begin
      if (mode == 0) begin awvalid = 1'b1; awready = 1'b1; end
      else           begin wvalid = 1'b1;  wready = 1'b1;  end
      step();
      awvalid = 1'b0; awready = 1'b0; wvalid = 1'b0; wready = 1'b0;
      check("wr_busy_half", {31'd0, wr_busy}, 32'd1);
      repeat (gap) step();
      if (mode == 0) begin wvalid = 1'b1;  wready = 1'b1;  end
      else           begin awvalid = 1'b1; awready = 1'b1; end
      step();
    end
    awvalid = 1'b0; awready = 1'b0; wvalid = 1'b0; wready = 1'b0;
    check("wr_busy_wait", {31'd0, wr_busy}, 32'd1);
    repeat (blat - 1) step();
    bvalid = 1'b1;
    bready = 1'b1;
    step();
    bvalid = 1'b0;
    bready = 1'b0;
    check("wr_busy_done", {31'd0, wr_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; clr = 1'b0;
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0;
    awaddr = '0; araddr = '0;
    mdl_rd = '0; mdl_wr = '0; mdl_last_rd = '0; mdl_last_wr = '0;
`ifdef AXI_MON_LATENCY_EN
    mdl_rd_lat_max = 0; mdl_wr_lat_max = 0;
`endif
    #1;
    check_all_zero("reset");
    #20 rst_n = 1'b1;
    step();

    // Single read, 3-cycle latency.
    rd_txn(32'h0000_0010, 0, 3);
    check("single_rd_errs", {30'd0, timeout_err, proto_err}, 32'd0);

    // W before AW, then AW and W together.
    wr_txn(32'h0000_0020, 1, 1, 2);
    wr_txn(32'h0000_0020, 2, 0, 3);
    check("wr_order_proto", {31'd0, proto_err}, 32'd0);

    // Asynchronous reset while a read is outstanding.
    araddr = 32'hDEAD_0040; arvalid = 1'b1; arready = 1'b1;
    step();
    arvalid = 1'b0; arready = 1'b0;
    check("pre_rst_busy", {31'd0, rd_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    mdl_rd = '0; mdl_wr = '0; mdl_last_rd = '0; mdl_last_wr = '0;
`ifdef AXI_MON_LATENCY_EN
    mdl_rd_lat_max = 0; mdl_wr_lat_max = 0;
`endif
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_errs", {30'd0, timeout_err, proto_err}, 32'd0);

    // Timeout: no R for 10 cycles, then a late R completes the read.
    araddr = 32'h0000_0080; arvalid = 1'b1; arready = 1'b1;
    step();
    arvalid = 1'b0; arready = 1'b0;
    note_rd(32'h0000_0080, 11);
    repeat (7) step();
    check("timeout_before", {31'd0, timeout_err}, 32'd0);
    step();
    check("timeout_at_8", {31'd0, timeout_err}, 32'd1);
    repeat (2) step();
    check("timeout_still_busy", {31'd0, rd_busy}, 32'd1);
    rvalid = 1'b1; rready = 1'b1;
    step();
    rvalid = 1'b0; rready = 1'b0;
    check("timeout_rd_idle", {31'd0, rd_busy}, 32'd0);
    check("timeout_proto", {31'd0, proto_err}, 32'd0);
    do_clr();
    check("timeout_cleared", {31'd0, timeout_err}, 32'd0);

    // arvalid withdrawn without a handshake.
    arvalid = 1'b1; arready = 1'b0;
    step(); step();
    arvalid = 1'b0;
    step();
    check("ar_drop_proto", {31'd0, proto_err}, 32'd1);
    check("ar_drop_idle", {31'd0, rd_busy}, 32'd0);
    do_clr();
    check("ar_drop_cleared", {31'd0, proto_err}, 32'd0);

    // B handshake with no write outstanding.
    bvalid = 1'b1; bready = 1'b1;
    step();
    bvalid = 1'b0; bready = 1'b0;
    check("stray_b_proto", {31'd0, proto_err}, 32'd1);
    check("stray_b_idle", {31'd0, wr_busy}, 32'd0);
    do_clr();
    check("stray_b_cleared", {31'd0, proto_err}, 32'd0);

`ifdef AXI_MON_LATENCY_EN
    rd_txn(32'h0000_0100, 0, 2);
    rd_txn(32'h0000_0104, 1, 5);
    rd_txn(32'h0000_0108, 0, 3);
    check("rd_lat_max_253", {16'd0, rd_lat_max}, 32'(mdl_rd_lat_max));
`endif

    // clr coinciding with an R handshake leaves rd_count at zero.
    rd_txn(32'h0000_0200, 0, 1);
    araddr = 32'h0000_0204; arvalid = 1'b1; arready = 1'b1;
    step();
    arvalid = 1'b0; arready = 1'b0;
    mdl_last_rd = 32'h0000_0204;
    step();
    prep_clr();
    rvalid = 1'b1; rready = 1'b1; clr = 1'b1;
    step();
    rvalid = 1'b0; rready = 1'b0; clr = 1'b0;
    check("clr_r_count", rd_count, 32'd0);
    check("clr_r_idle", {31'd0, rd_busy}, 32'd0);

    // Randomized legal traffic.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0)
        rd_txn(a, $urandom_range(0, 3), $urandom_range(1, 7));
      else
        wr_txn(a, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 6));
      if (i % 13 == 12) do_clr();
    end
    step(); step();
    check("final_errs", {30'd0, timeout_err, proto_err}, 32'd0);
`ifdef AXI_MON_LATENCY_EN
    check("final_rd_lat_max", {16'd0, rd_lat_max}, 32'(mdl_rd_lat_max));
    check("final_wr_lat_max", {16'd0, wr_lat_max}, 32'(mdl_wr_lat_max));
`endif
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
